// File: rtl/uart_tx_fifo_feeder_if.sv
// Host-write and transmitter-launch signals of uart_tx_fifo_feeder.
// Optional overflow flag ports exist only when UART_TXF_OVERFLOW_EN is defined.
interface uart_tx_fifo_feeder_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
`ifdef UART_TXF_OVERFLOW_EN
    logic              overflow;
    logic              ovf_clr;
`endif

    // Handshakes: wr_en is a one-cycle push that is taken only when full=0 at the
    // same edge. tx_start is a level request with tx_data held stable until the
    // transmitter raises tx_busy; a new request is made only after tx_busy is low.
`ifdef UART_TXF_OVERFLOW_EN
    modport master (output wr_en, wr_data, tx_busy, ovf_clr,
                    input  full, empty, count, tx_start, tx_data, overflow);
    modport slave  (input  wr_en, wr_data, tx_busy, ovf_clr,
                    output full, empty, count, tx_start, tx_data, overflow);
`else
    modport master (output wr_en, wr_data, tx_busy,
                    input  full, empty, count, tx_start, tx_data);
    modport slave  (input  wr_en, wr_data, tx_busy,
                    output full, empty, count, tx_start, tx_data);
`endif
endinterface

// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO and launch FSM feeding a UART transmitter one byte per tx_start/tx_busy handshake.
// Optional sticky overflow flag enabled by defining UART_TXF_OVERFLOW_EN.
module uart_tx_fifo_feeder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    uart_tx_fifo_feeder_if.slave  bus,
    output logic [1:0]            state_dbg
);
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push;
    logic              pop;

    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        push       = bus.wr_en && !full_q;
        case (state_q)
            // Refusing to launch while busy is high keeps a stale busy from
            // swallowing a request.
            IDLE: begin
                if (!empty_q && !bus.tx_busy) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                if (bus.tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = IDLE;
            end
        endcase

        wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, pop};
        // Pointers carry one extra wrap bit, so occupancy is their modular difference.
        count_d  = wr_ptr_d - rd_ptr_d;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                   (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.wr_data;
        end
    end

`ifdef UART_TXF_OVERFLOW_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (bus.wr_en && full_q) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow = overflow_q;
`endif

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign state_dbg    = state_q;
endmodule
